// File: rtl/gray_binary.sv
// Gray-to-binary stream decoder with valid/ready output register and modular step report.
// Define STEP_CHECK_EN to build the non-adjacent transition checker and saturating error counter.
module gray_binary #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     binary_out,
  output logic [WIDTH-1:0]     delta_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [0:0] {FIRST = 1'b0, TRACK = 1'b1} state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             first_s;
  logic             accept_s;
  logic [WIDTH-1:0] bin_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] binary_r;
  logic [WIDTH-1:0] delta_r;
  logic             out_valid_r;

  // Prefix-XOR from the MSB down: each binary bit folds in every Gray bit above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign bin_s      = gray_to_bin(gray_in);
  assign in_ready   = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign binary_out = binary_r;
  assign delta_out  = delta_r;
  assign out_valid  = out_valid_r;

  // Tracking state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FIRST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: leave FIRST on the first accepted sample; TRACK is only left by reset
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FIRST: begin
        if (accept_s) begin
          state_next_s = TRACK;
        end else begin
          state_next_s = FIRST;
        end
      end
      TRACK:   state_next_s = TRACK;
      default: state_next_s = FIRST;
    endcase
  end

  // State decode used by the datapath
  always_comb begin
    first_s = 1'b1;
    case (state_r)
      FIRST:   first_s = 1'b1;
      TRACK:   first_s = 1'b0;
      default: first_s = 1'b1;
    endcase
  end

  // Output register and previous-sample store; history moves only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      binary_r    <= {WIDTH{1'b0}};
      delta_r     <= {WIDTH{1'b0}};
      prev_r      <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      binary_r    <= bin_s;
      delta_r     <= first_s ? {WIDTH{1'b0}} : (bin_s - prev_r);
      prev_r      <= bin_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef STEP_CHECK_EN
  logic [WIDTH-1:0]     prev_gray_r;
  logic                 step_err_r;
  logic [ERR_CNT_W-1:0] err_count_r;
  logic                 bad_step_s;

  // True when two or more Gray bits changed between consecutive samples
  function automatic logic multi_flip(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + int'(d[i]);
    end
    return (n >= 2);
  endfunction

  assign bad_step_s = !first_s && multi_flip(gray_in ^ prev_gray_r);
  assign step_err   = step_err_r;
  assign err_count  = err_count_r;

  // Adjacency flag and saturating error counter, updated with each accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray_r <= {WIDTH{1'b0}};
      step_err_r  <= 1'b0;
      err_count_r <= {ERR_CNT_W{1'b0}};
    end else if (accept_s) begin
      prev_gray_r <= gray_in;
      step_err_r  <= bad_step_s;
      if (bad_step_s && (err_count_r != {ERR_CNT_W{1'b1}})) begin
        err_count_r <= err_count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  assign step_err  = 1'b0;
  assign err_count = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_gray_binary.sv
// Scoreboard bench for gray_binary: random and directed streams against a behavioural model.
`timescale 1ns/1ps
module tb_gray_binary;
  localparam int W  = 4;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  gray_in;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  binary_out;
  logic [W-1:0]  delta_out;
  logic          out_valid;
  logic          out_ready;
  logic          step_err;
  logic [EW-1:0] err_count;

  gray_binary #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .in_ready(in_ready),
    .binary_out(binary_out), .delta_out(delta_out), .out_valid(out_valid),
    .out_ready(out_ready), .step_err(step_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int delta;
    int err;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // model state
  bit m_first = 1'b1;
  int m_prev_bin = 0;
  int m_prev_gray = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Binary value whose Gray code is g, computed by brute force over the encoding b ^ (b>>1)
  function automatic int model_decode(input int g);
    for (int b = 0; b < (1 << W); b++) begin
      if (((b ^ (b >> 1)) % (1 << W)) == g) return b;
    end
    return -1;
  endfunction

  // Monitor pops on consume; scoreboard pushes on accept; both sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_first = 1'b1; m_prev_bin = 0; m_prev_gray = 0; m_cnt = 0;
    end else begin
      chk("out_valid_vs_pending", int'(out_valid), int'(q.size() != 0));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("binary_out", int'(binary_out), e.bin);
          chk("delta_out",  int'(delta_out),  e.delta);
          chk("step_err",   int'(step_err),   e.err);
          chk("err_count",  int'(err_count),  e.cnt);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int g;
        g = int'(gray_in);
        e.bin   = model_decode(g);
        e.delta = m_first ? 0 : ((e.bin - m_prev_bin + (1 << W)) % (1 << W));
`ifdef STEP_CHECK_EN
        e.err = (!m_first && ($countones(g ^ m_prev_gray) >= 2)) ? 1 : 0;
        if (e.err == 1 && m_cnt < (1 << EW) - 1) m_cnt++;
        e.cnt = m_cnt;
`else
        e.err = 0;
        e.cnt = 0;
`endif
        m_first = 1'b0; m_prev_bin = e.bin; m_prev_gray = g;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [W-1:0] g);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    gray_in  = g;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int exp_err;
    rst = 1'b1; in_valid = 1'b1; gray_in = 4'b0000; out_ready = 1'b1;
    do_reset(2);
    in_valid = 1'b0;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_binary",    int'(binary_out), 0);
    chk("rst_in_ready",  int'(in_ready), 1);

    send(4'b0110);
    chk("first_binary", int'(binary_out), 4);
    chk("first_delta",  int'(delta_out), 0);
    chk("first_err",    int'(step_err), 0);

    // stream 0..3, continuous valid
    send(4'b0000); send(4'b0001); send(4'b0011);
    chk("stream_valid", int'(out_valid), 1);
    send(4'b0010);
    chk("stream_bin3", int'(binary_out), 3);
    chk("stream_delta", int'(delta_out), 1);

    // wrap 15 -> 0
    send(4'b1000);
    chk("wrap_bin15", int'(binary_out), 15);
    send(4'b0000);
    chk("wrap_bin0",  int'(binary_out), 0);
    chk("wrap_delta", int'(delta_out), 1);
    chk("wrap_err",   int'(step_err), 0);

    // non-adjacent step
`ifdef STEP_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    do_reset(1);
    send(4'b0000); send(4'b0011);
    chk("err_binary", int'(binary_out), 2);
    chk("err_delta",  int'(delta_out), 2);
    chk("err_flag",   int'(step_err), exp_err);
    chk("err_count1", int'(err_count), exp_err);
    for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 4'b0000 : 4'b0011);
    chk("err_saturate", int'(err_count), exp_err * 255);
    send(4'b0000);
    chk("err_sat_hold", int'(err_count), exp_err * 255);

    // backpressure
    send(4'b0101);
    chk("bp_binary", int'(binary_out), 6);
    out_ready = 1'b0; in_valid = 1'b1; gray_in = 4'b0100;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_hold",     int'(binary_out), 6);
      chk("bp_valid",    int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_binary", int'(binary_out), 7);
    chk("bp_next_delta",  int'(delta_out), 1);

    // reset while output is held
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", int'(out_valid), 0);
    rst = 1'b0; out_ready = 1'b1;
    send(4'b1111);
    chk("midrst_binary", int'(binary_out), 10);
    chk("midrst_delta",  int'(delta_out), 0);
    chk("midrst_err",    int'(step_err), 0);

    // random traffic, mostly single-bit steps with occasional jumps
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) gray_in = W'($urandom);
      else if ($urandom_range(0, 2) != 0) gray_in = gray_in ^ W'(1 << $urandom_range(0, W - 1));
      @(posedge clk); #1;
      if ($urandom_range(0, 150) == 0) begin
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
